// File: rtl/ysyx_040066_mem_access_pkg.sv
// Shared types and widths for the memory-access stage: datapath width,
// MemOp size encodings and the request FSM states.
package ysyx_040066_mem_access_pkg;

    localparam int XLEN   = 64;
    localparam int MASK_W = XLEN / 8;

    // MemOp[1:0] access size; MemOp[2] selects zero extension in write-back
    typedef enum logic [1:0] {
        MOP_B = 2'd0,
        MOP_H = 2'd1,
        MOP_W = 2'd2,
        MOP_D = 2'd3
    } mop_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/ysyx_040066_mem_access_if.sv
// Data-memory req/ack bus between the memory-access stage (master) and the
// memory system (slave).
interface ysyx_040066_mem_access_if;
    import ysyx_040066_mem_access_pkg::*;

    logic              mem_req;
    logic              mem_wr;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_err;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata, mem_wmask,
        input  mem_ack, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata, mem_wmask,
        output mem_ack, mem_rdata, mem_err
    );

endinterface

// File: rtl/ysyx_040066_store_align.sv
// Store lane replication, byte-strobe generation and natural-alignment check
// for a given access size and byte offset within the 8-byte word.
module ysyx_040066_store_align
    import ysyx_040066_mem_access_pkg::*;
(
    input  logic [1:0]        i_size,
    input  logic [2:0]        i_offset,
    input  logic [XLEN-1:0]   i_sdata,
    output logic [XLEN-1:0]   o_wdata,
    output logic [MASK_W-1:0] o_wmask,
    output logic              o_misalign
);

    always_comb begin
        o_wdata    = i_sdata;
        o_wmask    = '1;
        o_misalign = 1'b0;
        case (mop_size_t'(i_size))
            MOP_B: begin
                o_wdata = {8{i_sdata[7:0]}};
                o_wmask = 8'h01 << i_offset;
            end
            MOP_H: begin
                o_wdata    = {4{i_sdata[15:0]}};
                o_wmask    = 8'h03 << i_offset;
                o_misalign = i_offset[0];
            end
            MOP_W: begin
                o_wdata    = {2{i_sdata[31:0]}};
                o_wmask    = 8'h0F << i_offset;
                o_misalign = |i_offset[1:0];
            end
            default: begin
                o_misalign = |i_offset;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_040066_mem_access.sv
// Memory-access pipeline stage: registers EX results, issues one data-memory
// request per load/store and holds the pipeline until it completes.
module ysyx_040066_mem_access
    import ysyx_040066_mem_access_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              i_valid_in,
    input  logic              i_wen_in,
    input  logic              i_MemRd_in,
    input  logic              i_MemWr_in,
    input  logic              i_done_in,
    input  logic              i_error_in,
    input  logic [4:0]        i_rd_in,
    input  logic [XLEN-1:0]   i_alu_in,
    input  logic [XLEN-1:0]   i_sdata_in,
    input  logic [XLEN-1:0]   i_nxtpc_in,
    input  logic [2:0]        i_MemOp_in,

    ysyx_040066_mem_access_if.master mem,

    output logic              o_block,
    output logic              o_valid_out,
    output logic              o_wen_out,
    output logic              o_MemRd_out,
    output logic              o_MemWr_out,
    output logic              o_done_out,
    output logic              o_error_out,
    output logic [4:0]        o_rd_out,
    output logic [XLEN-1:0]   o_data_out,
    output logic [XLEN-1:0]   o_nxtpc_out,
    output logic [2:0]        o_MemOp_out,
    output logic [2:0]        o_addr_lowbit_out,
    output logic [XLEN-1:0]   o_data_Rd,
    output logic              o_data_error
);

    state_t            r_state;
    logic              r_valid, r_wen, r_memrd, r_memwr, r_done, r_error;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_alu, r_sdata, r_nxtpc;
    logic [2:0]        r_memop;
    logic              r_served;
    logic [XLEN-1:0]   r_rdata;
    logic              r_err;

    logic              w_need;
    logic              w_misalign;
    logic              w_req;
    logic [XLEN-1:0]   w_wdata;
    logic [MASK_W-1:0] w_wmask;

    ysyx_040066_store_align u_store_align (
        .i_size     (r_memop[1:0]),
        .i_offset   (r_alu[2:0]),
        .i_sdata    (r_sdata),
        .o_wdata    (w_wdata),
        .o_wmask    (w_wmask),
        .o_misalign (w_misalign)
    );

    assign w_need  = r_valid && (r_memrd || r_memwr) && !r_error;
    assign o_block = w_need && !r_served;
    // Request is a function of registered state only, so it never follows mem_ack
    assign w_req   = (r_state == WAIT) ||
                     ((r_state == IDLE) && w_need && !r_served && !w_misalign);

    assign mem.mem_req   = w_req;
    assign mem.mem_wr    = w_req && r_memwr;
    assign mem.mem_addr  = {r_alu[XLEN-1:3], 3'b000};
    assign mem.mem_wdata = w_wdata;
    assign mem.mem_wmask = (w_req && r_memwr) ? w_wmask : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_wen    <= 1'b0;
            r_memrd  <= 1'b0;
            r_memwr  <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_rd     <= '0;
            r_alu    <= '0;
            r_sdata  <= '0;
            r_nxtpc  <= '0;
            r_memop  <= '0;
            r_served <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            // Served is only set while blocked, so it never races the capture clear
            if (!o_block) begin
                r_valid  <= i_valid_in;
                r_wen    <= i_wen_in;
                r_memrd  <= i_MemRd_in;
                r_memwr  <= i_MemWr_in;
                r_done   <= i_done_in;
                r_error  <= i_error_in;
                r_rd     <= i_rd_in;
                r_alu    <= i_alu_in;
                r_sdata  <= i_sdata_in;
                r_nxtpc  <= i_nxtpc_in;
                r_memop  <= i_MemOp_in;
                r_served <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_need && !r_served) begin
                        if (w_misalign) begin
                            r_err    <= 1'b1;
                            r_served <= 1'b1;
                        end else if (mem.mem_ack) begin
                            if (r_memrd) begin
                                r_rdata <= mem.mem_rdata;
                            end
                            r_err    <= mem.mem_err;
                            r_served <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_ack) begin
                        if (r_memrd) begin
                            r_rdata <= mem.mem_rdata;
                        end
                        r_err    <= mem.mem_err;
                        r_served <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_valid_out       = r_valid;
    assign o_wen_out         = r_wen;
    assign o_MemRd_out       = r_memrd;
    assign o_MemWr_out       = r_memwr;
    assign o_done_out        = r_done;
    assign o_error_out       = r_error;
    assign o_rd_out          = r_rd;
    assign o_data_out        = r_alu;
    assign o_nxtpc_out       = r_nxtpc;
    assign o_MemOp_out       = r_memop;
    assign o_addr_lowbit_out = r_alu[2:0];
    assign o_data_Rd         = r_rdata;
    assign o_data_error      = r_err && !(r_valid && !(r_memrd || r_memwr));

endmodule

// File: tb/tb_ysyx_040066_mem_access.sv
// Directed self-checking bench for the memory-access stage: loads, stores,
// misalignment, bus error, upstream error and reset during a pending access.
module tb_ysyx_040066_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        valid_in, wen_in, MemRd_in, MemWr_in, done_in, error_in;
    logic [4:0]  rd_in;
    logic [63:0] alu_in, sdata_in, nxtpc_in;
    logic [2:0]  MemOp_in;

    logic        block, valid_out, wen_out, MemRd_out, MemWr_out, done_out, error_out;
    logic [4:0]  rd_out;
    logic [63:0] data_out, nxtpc_out, data_Rd;
    logic [2:0]  MemOp_out, addr_lowbit_out;
    logic        data_error;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_040066_mem_access_if mem_bus ();

    ysyx_040066_mem_access dut (
        .clk               (clk),
        .rst               (rst),
        .i_valid_in        (valid_in),
        .i_wen_in          (wen_in),
        .i_MemRd_in        (MemRd_in),
        .i_MemWr_in        (MemWr_in),
        .i_done_in         (done_in),
        .i_error_in        (error_in),
        .i_rd_in           (rd_in),
        .i_alu_in          (alu_in),
        .i_sdata_in        (sdata_in),
        .i_nxtpc_in        (nxtpc_in),
        .i_MemOp_in        (MemOp_in),
        .mem               (mem_bus.master),
        .o_block           (block),
        .o_valid_out       (valid_out),
        .o_wen_out         (wen_out),
        .o_MemRd_out       (MemRd_out),
        .o_MemWr_out       (MemWr_out),
        .o_done_out        (done_out),
        .o_error_out       (error_out),
        .o_rd_out          (rd_out),
        .o_data_out        (data_out),
        .o_nxtpc_out       (nxtpc_out),
        .o_MemOp_out       (MemOp_out),
        .o_addr_lowbit_out (addr_lowbit_out),
        .o_data_Rd         (data_Rd),
        .o_data_error      (data_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rdl, input logic wrl, input logic err,
                         input logic [2:0] op, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] sdata);
        valid_in = v;
        wen_in   = rdl;
        MemRd_in = rdl;
        MemWr_in = wrl;
        done_in  = v;
        error_in = err;
        MemOp_in = op;
        rd_in    = rd;
        alu_in   = alu;
        sdata_in = sdata;
        nxtpc_in = alu + 64'd4;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [63:0] alu);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, rd, alu, 64'd0);
        wen_in = 1'b1;
    endtask

    task automatic drive_nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 64'd0, 64'd0);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 5'd1, 64'h8000_0040, 64'd0);
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 64'd0;
        mem_bus.mem_err   = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", mem_bus.mem_req); end
        n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL rst_block: got %b want 0", block); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid_out); end
        n_cmp++; if (data_Rd !== 64'd0) begin n_bad++; $display("FAIL rst_dataRd: got %h want 0", data_Rd); end
        n_cmp++; if (mem_bus.mem_addr !== 64'd0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", mem_bus.mem_addr); end
        drive_nop();
        #3 rst = 1'b0;
        step();
        n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL rst_nop_block: got %b want 0", block); end
        $display("reset: req=%b block=%b valid_out=%b", mem_bus.mem_req, block, valid_out);
    endtask

    // ld at 0x80000010, ack in the third request cycle: block high 3 cycles
    task automatic test_load();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 5'd10, 64'h8000_0010, 64'd0);
        step();
        drive_nop();
        n_cmp++; if (mem_bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL ld_req: got %b want 1", mem_bus.mem_req); end
        n_cmp++; if (mem_bus.mem_addr !== 64'h8000_0010) begin n_bad++; $display("FAIL ld_addr: got %h want 80000010", mem_bus.mem_addr); end
        n_cmp++; if (mem_bus.mem_wr !== 1'b0) begin n_bad++; $display("FAIL ld_wr: got %b want 0", mem_bus.mem_wr); end
        n_cmp++; if (mem_bus.mem_wmask !== 8'h00) begin n_bad++; $display("FAIL ld_wmask: got %h want 00", mem_bus.mem_wmask); end
        n_cmp++; if (block !== 1'b1) begin n_bad++; $display("FAIL ld_block1: got %b want 1", block); end
        step();
        n_cmp++; if (block !== 1'b1) begin n_bad++; $display("FAIL ld_block2: got %b want 1", block); end
        n_cmp++; if (mem_bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL ld_req_wait: got %b want 1", mem_bus.mem_req); end
        step();
        n_cmp++; if (block !== 1'b1) begin n_bad++; $display("FAIL ld_block3: got %b want 1", block); end
        n_cmp++; if (mem_bus.mem_addr !== 64'h8000_0010) begin n_bad++; $display("FAIL ld_addr_stable: got %h want 80000010", mem_bus.mem_addr); end
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 64'h1122_3344_5566_7788;
        mem_bus.mem_err   = 1'b0;
        step();
        mem_bus.mem_ack = 1'b0;
        n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL ld_release: got %b want 0", block); end
        n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL ld_req_done: got %b want 0", mem_bus.mem_req); end
        n_cmp++; if (data_Rd !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL ld_dataRd: got %h want 1122334455667788", data_Rd); end
        n_cmp++; if (data_error !== 1'b0) begin n_bad++; $display("FAIL ld_derr: got %b want 0", data_error); end
        n_cmp++; if (MemRd_out !== 1'b1) begin n_bad++; $display("FAIL ld_MemRd_out: got %b want 1", MemRd_out); end
        n_cmp++; if (rd_out !== 5'd10) begin n_bad++; $display("FAIL ld_rd_out: got %0d want 10", rd_out); end
        n_cmp++; if (nxtpc_out !== 64'h8000_0014) begin n_bad++; $display("FAIL ld_nxtpc: got %h want 80000014", nxtpc_out); end
        $display("ld  addr=80000010 data_Rd=%h data_error=%b", data_Rd, data_error);
    endtask

    // sb 0xAB at 0x80000005 with ack in the request cycle
    task automatic test_store_byte();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'h8000_0005, 64'h1122_3344_5566_77AB);
        step();
        drive_nop();
        n_cmp++; if (mem_bus.mem_wmask !== 8'h20) begin n_bad++; $display("FAIL sb_wmask: got %h want 20", mem_bus.mem_wmask); end
        n_cmp++; if (mem_bus.mem_wdata !== 64'hABAB_ABAB_ABAB_ABAB) begin n_bad++; $display("FAIL sb_wdata: got %h want abababababababab", mem_bus.mem_wdata); end
        n_cmp++; if (mem_bus.mem_wr !== 1'b1) begin n_bad++; $display("FAIL sb_wr: got %b want 1", mem_bus.mem_wr); end
        n_cmp++; if (mem_bus.mem_addr !== 64'h8000_0000) begin n_bad++; $display("FAIL sb_addr: got %h want 80000000", mem_bus.mem_addr); end
        n_cmp++; if (block !== 1'b1) begin n_bad++; $display("FAIL sb_block: got %b want 1", block); end
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        mem_bus.mem_err   = 1'b0;
        step();
        mem_bus.mem_ack = 1'b0;
        n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL sb_release: got %b want 0", block); end
        n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL sb_req_done: got %b want 0", mem_bus.mem_req); end
        n_cmp++; if (data_Rd !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL sb_dataRd_kept: got %h want 1122334455667788", data_Rd); end
        n_cmp++; if (MemWr_out !== 1'b1) begin n_bad++; $display("FAIL sb_MemWr_out: got %b want 1", MemWr_out); end
        $display("sb  addr=80000005 mask=20 data_Rd=%h", data_Rd);
    endtask

    // lw at 0x80000006 is misaligned; an add follows immediately
    task automatic test_misalign();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 5'd4, 64'h8000_0006, 64'd0);
        step();
        drive_alu(5'd7, 64'h0000_0000_0000_1234);
        n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL mis_req: got %b want 0", mem_bus.mem_req); end
        n_cmp++; if (block !== 1'b1) begin n_bad++; $display("FAIL mis_block: got %b want 1", block); end
        step();
        n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL mis_release: got %b want 0", block); end
        n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL mis_req2: got %b want 0", mem_bus.mem_req); end
        n_cmp++; if (data_error !== 1'b1) begin n_bad++; $display("FAIL mis_derr: got %b want 1", data_error); end
        n_cmp++; if (addr_lowbit_out !== 3'd6) begin n_bad++; $display("FAIL mis_lowbit: got %0d want 6", addr_lowbit_out); end
        n_cmp++; if (data_Rd !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL mis_dataRd_kept: got %h want 1122334455667788", data_Rd); end
        step();
        drive_nop();
        n_cmp++; if (data_out !== 64'h1234) begin n_bad++; $display("FAIL add1_data_out: got %h want 1234", data_out); end
        n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL add1_block: got %b want 0", block); end
        n_cmp++; if (data_error !== 1'b0) begin n_bad++; $display("FAIL add1_derr_forced: got %b want 0", data_error); end
        n_cmp++; if (rd_out !== 5'd7) begin n_bad++; $display("FAIL add1_rd_out: got %0d want 7", rd_out); end
        $display("lw  addr=80000006 misaligned, add data_out=%h", data_out);
    endtask

    // lwu with immediate ack, then an add one cycle behind it
    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 5'd9, 64'h8000_0008, 64'd0);
        step();
        drive_alu(5'd3, 64'h0000_0000_0000_55AA);
        n_cmp++; if (mem_bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL b2b_req: got %b want 1", mem_bus.mem_req); end
        n_cmp++; if (mem_bus.mem_addr !== 64'h8000_0008) begin n_bad++; $display("FAIL b2b_addr: got %h want 80000008", mem_bus.mem_addr); end
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 64'hCAFE_BABE_0BAD_F00D;
        mem_bus.mem_err   = 1'b0;
        step();
        mem_bus.mem_ack = 1'b0;
        n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL b2b_release: got %b want 0", block); end
        n_cmp++; if (data_Rd !== 64'hCAFE_BABE_0BAD_F00D) begin n_bad++; $display("FAIL b2b_dataRd: got %h want cafebabe0badf00d", data_Rd); end
        n_cmp++; if (data_error !== 1'b0) begin n_bad++; $display("FAIL b2b_derr: got %b want 0", data_error); end
        n_cmp++; if (MemOp_out !== 3'd6) begin n_bad++; $display("FAIL b2b_MemOp_out: got %0d want 6", MemOp_out); end
        step();
        drive_nop();
        n_cmp++; if (data_out !== 64'h55AA) begin n_bad++; $display("FAIL add2_data_out: got %h want 55aa", data_out); end
        n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL add2_block: got %b want 0", block); end
        n_cmp++; if (data_Rd !== 64'hCAFE_BABE_0BAD_F00D) begin n_bad++; $display("FAIL add2_dataRd_kept: got %h want cafebabe0badf00d", data_Rd); end
        $display("lwu addr=80000008 data_Rd=%h then add data_out=%h", data_Rd, data_out);
    endtask

    // sh 0x1234 at offset 2 with a bus error on the ack
    task automatic test_store_err();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 5'd0, 64'h8000_0002, 64'hDEAD_0000_0000_1234);
        step();
        drive_nop();
        n_cmp++; if (mem_bus.mem_wmask !== 8'h0C) begin n_bad++; $display("FAIL sh_wmask: got %h want 0c", mem_bus.mem_wmask); end
        n_cmp++; if (mem_bus.mem_wdata !== 64'h1234_1234_1234_1234) begin n_bad++; $display("FAIL sh_wdata: got %h want 1234123412341234", mem_bus.mem_wdata); end
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 64'h0;
        mem_bus.mem_err   = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_err = 1'b0;
        n_cmp++; if (data_error !== 1'b1) begin n_bad++; $display("FAIL sh_derr: got %b want 1", data_error); end
        n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL sh_release: got %b want 0", block); end
        n_cmp++; if (data_Rd !== 64'hCAFE_BABE_0BAD_F00D) begin n_bad++; $display("FAIL sh_dataRd_kept: got %h want cafebabe0badf00d", data_Rd); end
        $display("sh  addr=80000002 mask=0c bus error data_error=%b", data_error);
    endtask

    // upstream error on a load; a stray ack in that cycle is ignored
    task automatic test_error_in();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 5'd2, 64'h8000_0018, 64'd0);
        step();
        drive_nop();
        n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL errin_req: got %b want 0", mem_bus.mem_req); end
        n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL errin_block: got %b want 0", block); end
        n_cmp++; if (error_out !== 1'b1) begin n_bad++; $display("FAIL errin_error_out: got %b want 1", error_out); end
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 64'h9999_9999_9999_9999;
        step();
        mem_bus.mem_ack = 1'b0;
        n_cmp++; if (data_Rd !== 64'hCAFE_BABE_0BAD_F00D) begin n_bad++; $display("FAIL stray_ack_dataRd: got %h want cafebabe0badf00d", data_Rd); end
        n_cmp++; if (error_out !== 1'b0) begin n_bad++; $display("FAIL errin_clear: got %b want 0", error_out); end
        $display("ld  addr=80000018 error_in: error_out passed, no request");
    endtask

    // reset while the request is pending; the late ack must not land
    task automatic test_reset_wait();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 5'd6, 64'h8000_0020, 64'd0);
        step();
        drive_nop();
        step();
        n_cmp++; if (mem_bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL rw_req_wait: got %b want 1", mem_bus.mem_req); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL rw_req_drop: got %b want 0", mem_bus.mem_req); end
        n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL rw_block_drop: got %b want 0", block); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rw_valid: got %b want 0", valid_out); end
        n_cmp++; if (data_Rd !== 64'd0) begin n_bad++; $display("FAIL rw_dataRd_rst: got %h want 0", data_Rd); end
        #1 rst = 1'b0;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        mem_bus.mem_ack = 1'b0;
        n_cmp++; if (data_Rd !== 64'd0) begin n_bad++; $display("FAIL rw_late_ack: got %h want 0", data_Rd); end
        n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL rw_req_after: got %b want 0", mem_bus.mem_req); end
        n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL rw_block_after: got %b want 0", block); end
        $display("ld  addr=80000020 reset mid-wait, data_Rd=%h", data_Rd);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_byte();
        test_misalign();
        test_back_to_back();
        test_store_err();
        test_error_in();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_040066_mem_access.md
Name: ysyx_040066_mem_access

Overview:
- Memory-access pipeline stage between EX and the write-back stage.
- Registers the EX outputs and issues one data-memory request per load or store over a req/ack bus.
- Holds the whole pipeline with `block` until the response arrives.
- Presents the registered instruction fields plus the raw 64-bit read word and error flag to write-back. Write-back does the byte/half/word selection and sign extension.

Parameters:
XLEN, 64, datapath and address width
MASK_W, 8, write-strobe width (XLEN/8)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
valid_in  in  1  EX slot holds an instruction
wen_in  in  1  instruction writes rd
MemRd_in  in  1  load
MemWr_in  in  1  store
done_in  in  1  instruction retires (passed through)
error_in  in  1  upstream exception
rd_in  in  5  destination register
alu_in  in  XLEN  ALU result / effective address
sdata_in  in  XLEN  store data (rs2)
nxtpc_in  in  XLEN  next PC
MemOp_in  in  3  [1:0] size b/h/w/d, [2] unsigned
mem_req  out  1  request valid
mem_wr  out  1  1=write, 0=read
mem_addr  out  XLEN  8-byte-aligned address
mem_wdata  out  XLEN  lane-replicated store data
mem_wmask  out  MASK_W  byte strobes
mem_ack  in  1  response/completion this cycle
mem_rdata  in  XLEN  read word
mem_err  in  1  bus error
block  out  1  pipeline hold
valid_out, wen_out, MemRd_out, MemWr_out, done_out, error_out  out  1 each  registered fields to WB
rd_out  out  5  to WB
data_out  out  XLEN  ALU result to WB
nxtpc_out  out  XLEN  to WB
MemOp_out  out  3  to WB
addr_lowbit_out  out  3  alu_q[2:0] to WB
data_Rd  out  XLEN  captured read word
data_error  out  1  captured access error

Behaviour:
- Reset (async): all registers clear to 0; state IDLE; all outputs 0 (mem_req=0, block=0).
- Capture: on posedge with block=0, all *_in fields load into *_q and served_q<=0. With block=1, all *_q hold.
- need = valid_q && (MemRd_q||MemWr_q) && !error_q.
- misalign: h && alu_q[0]; w && alu_q[1:0]!=0; d && alu_q[2:0]!=0.
- FSM states IDLE, WAIT:
  - IDLE: if need && !served_q && !misalign, drive mem_req=1. On mem_ack go to IDLE with served_q<=1; otherwise go to WAIT.
  - IDLE misaligned: if need && misalign, issue no request; err_q<=1, served_q<=1 next cycle.
  - WAIT: mem_req=1 held with stable addr/wdata/mask. On mem_ack, capture, served_q<=1, go to IDLE.
- Capture on ack: rdata_q<=mem_rdata (loads only; stores leave it unchanged); err_q<=mem_err.
- block = need && !served_q (no combinational path from mem_ack).
  - A memory instruction costs at least 1 block cycle; an ack in the request cycle releases block the next cycle.
- Non-memory instruction: block=0; rdata_q and err_q unchanged; data_error forced 0 whenever valid_q && !(MemRd_q||MemWr_q).
- data_Rd=rdata_q and data_error=err_q are held stable until the next access completes. Write-back consumes them in the cycle after handover.
- Store lanes, with o=alu_q[2:0]:
  - b: wdata = byte x8, mask = 8'h01<<o
  - h: wdata = half x4, mask = 8'h03<<o
  - w: wdata = word x2, mask = 8'h0F<<o
  - d: wdata = sdata, mask = 8'hFF
- Loads: mem_wmask=0, mem_wr=0. mem_addr={alu_q[XLEN-1:3],3'b0}.
- error_in=1 on a memory instruction: no request, no block; fields pass to write-back with error_out=1.
- Reset during WAIT: mem_req drops immediately. A later mem_ack is ignored (state IDLE, valid_q=0).
- mem_ack while not requesting: ignored.

Decomposition:
- Shared package: MemOp size encodings (MOP_B/H/W/D), state enum {IDLE,WAIT}, XLEN.
- One sub-module, ysyx_040066_store_align (combinational lane replication and mask from MemOp and offset). Misalignment detection also lives there.

Test Plan:
- ld at addr 0x80000010, ack 2 cycles after req → block high 3 cycles; mem_addr=0x80000010; data_Rd=mem_rdata; data_error=0; MemRd_out=1.
- sb data 0xAB at 0x80000005, immediate ack → mem_wmask=8'h20, mem_wdata=0xABABABABABABABAB, mem_wr=1, block high 1 cycle.
- lw at 0x80000006 → no mem_req, data_error=1 after 1 block cycle, error not raised on bus.
- add (no memory) back-to-back after a load → block=0, data_out=alu_in delayed 1 cycle, data_error=0.
- rst asserted mid-WAIT, ack arrives next cycle → mem_req and block 0 immediately, valid_out=0, rdata_q stays 0.
- sh 0x1234 at 0x..2, mem_err=1 on ack → mask=8'h0C, wdata=0x1234123412341234, data_error=1.
